// File: rtl/triple_operand_datapath_pkg.sv
// Shared definitions for the triple-operand datapath: step codes, phases, modes.
package triple_operand_datapath_pkg;

  localparam logic [1:0] STEP_LOAD = 2'd0;
  localparam logic [1:0] STEP_OPB  = 2'd1;
  localparam logic [1:0] STEP_OPC  = 2'd2;
  localparam logic [1:0] STEP_FIN  = 2'd3;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_LOADED = 2'd1,
    PH_B_DONE = 2'd2,
    PH_C_DONE = 2'd3
  } phase_e;

  // Priority decode: s0 low means LOAD and s1/s2 are never looked at,
  // so an undriven s1/s2 during LOAD cannot leak into the step code.
  function automatic logic [1:0] decode_step(input logic s0, input logic s1, input logic s2);
    if (!s0) begin
      return STEP_LOAD;
    end else if (!s1) begin
      return STEP_OPB;
    end else if (!s2) begin
      return STEP_OPC;
    end else begin
      return STEP_FIN;
    end
  endfunction

endpackage

// File: rtl/triple_operand_datapath_addsub_ovf.sv
// Combinational WIDTH-bit add/subtract with signed-overflow detection.
module triple_operand_datapath_addsub_ovf
  import triple_operand_datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             m,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  // Wrap-around add or subtract; overflow judged on the sign bits only.
  always_comb begin
    sum = '0;
    ovf = 1'b0;
    if (m == MODE_ADD) begin
      sum = x + y;
      ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end else begin
      sum = x - y;
      ovf = (x[WIDTH-1] != y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end
  end

endmodule

// File: rtl/triple_operand_datapath.sv
// Four-step accumulate datapath (LOAD, OPB, OPC, FIN) with capture, counter
// and sticky step-order error.
//
// state     | meaning
// ----------+---------------------------------------------
// PH_IDLE   | no computation in flight (after reset/capture)
// PH_LOADED | acc holds A, waiting for OPB
// PH_B_DONE | acc holds A+/-B, waiting for OPC
// PH_C_DONE | acc holds final value, waiting for FIN+done
module triple_operand_datapath
  import triple_operand_datapath_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             e,
  input  logic             m,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  input  logic             done,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_count,
  output logic             seq_err
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_acc_q, ovf_acc_d;
  phase_e           phase_q, phase_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             result_valid_q, result_valid_d;
  logic [CNT_W-1:0] result_count_q, result_count_d;
  logic             seq_err_q, seq_err_d;

  logic [1:0]       step;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_ovf;

  assign step    = decode_step(s0, s1, s2);
  // One shared adder: OPC uses C, everything else presents B.
  assign operand = (step == STEP_OPC) ? c : b;

  triple_operand_datapath_addsub_ovf #(.WIDTH(WIDTH)) u_addsub (
    .x   (acc_q),
    .y   (operand),
    .m   (m),
    .sum (alu_sum),
    .ovf (alu_ovf)
  );

  // Next-state for phase, accumulator, capture registers and error flag.
  always_comb begin
    acc_d          = acc_q;
    ovf_acc_d      = ovf_acc_q;
    phase_d        = phase_q;
    result_d       = result_q;
    ovf_d          = ovf_q;
    result_valid_d = 1'b0;
    result_count_d = result_count_q;
    seq_err_d      = seq_err_q;
    if (e) begin
      case (step)
        STEP_LOAD: begin
          acc_d     = a;
          ovf_acc_d = 1'b0;
          phase_d   = PH_LOADED;
        end
        STEP_OPB: begin
          if (phase_q == PH_LOADED) begin
            acc_d     = alu_sum;
            ovf_acc_d = ovf_acc_q | alu_ovf;
            phase_d   = PH_B_DONE;
          end else begin
            seq_err_d = 1'b1;
          end
        end
        STEP_OPC: begin
          if (phase_q == PH_B_DONE) begin
            acc_d     = alu_sum;
            ovf_acc_d = ovf_acc_q | alu_ovf;
            phase_d   = PH_C_DONE;
          end else begin
            seq_err_d = 1'b1;
          end
        end
        default: begin
          // FIN without done is a no-op, not an error.
          if (done) begin
            if (phase_q == PH_C_DONE) begin
              result_d       = acc_q;
              ovf_d          = ovf_acc_q;
              result_valid_d = 1'b1;
              result_count_d = result_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
              phase_d        = PH_IDLE;
            end else begin
              seq_err_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q          <= '0;
      ovf_acc_q      <= 1'b0;
      phase_q        <= PH_IDLE;
      result_q       <= '0;
      ovf_q          <= 1'b0;
      result_valid_q <= 1'b0;
      result_count_q <= '0;
      seq_err_q      <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      ovf_acc_q      <= ovf_acc_d;
      phase_q        <= phase_d;
      result_q       <= result_d;
      ovf_q          <= ovf_d;
      result_valid_q <= result_valid_d;
      result_count_q <= result_count_d;
      seq_err_q      <= seq_err_d;
    end
  end

  assign result       = result_q;
  assign ovf          = ovf_q;
  assign result_valid = result_valid_q;
  assign result_count = result_count_q;
  assign seq_err      = seq_err_q;

endmodule

// File: tb/tb_triple_operand_datapath.sv
// Scoreboard bench for triple_operand_datapath (WIDTH=8, CNT_W=8).
module tb_triple_operand_datapath;

  localparam int K_LOAD = 0;
  localparam int K_OPB  = 1;
  localparam int K_OPC  = 2;
  localparam int K_FIN  = 3;

  typedef struct packed {
    logic [7:0] res;
    logic       ov;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       e = 1'b0, m = 1'b0, s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, done = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0;
  logic [7:0] result;
  logic       ovf, result_valid, seq_err;
  logic [7:0] result_count;

  int tests = 0;
  int fails = 0;

  exp_t sb[$];
  // bench reference model
  logic [7:0] m_acc = '0;
  logic       m_ov = 1'b0;
  int         m_ph = 0;
  logic       m_err = 1'b0;
  logic [7:0] m_cnt = '0;
  int         pulses = 0;
  logic       prev_valid = 1'b0;

  triple_operand_datapath #(.WIDTH(8), .CNT_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .e            (e),
    .m            (m),
    .s0           (s0),
    .s1           (s1),
    .s2           (s2),
    .done         (done),
    .a            (a),
    .b            (b),
    .c            (c),
    .result       (result),
    .ovf          (ovf),
    .result_valid (result_valid),
    .result_count (result_count),
    .seq_err      (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // signed reference arithmetic: range check on true integers
  task automatic model_apply(input logic mm, input logic [7:0] op);
    int r;
    r = mm ? (int'($signed(m_acc)) + int'($signed(op))) : (int'($signed(m_acc)) - int'($signed(op)));
    if (r > 127 || r < -128) m_ov = 1'b1;
    m_acc = r[7:0];
  endtask

  task automatic do_step(input int kind, input logic mm, input logic dn,
                         input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] cc,
                         input logic xsel);
    @(negedge clk);
    e = 1'b1; m = mm; done = dn; a = aa; b = bb; c = cc;
    case (kind)
      K_LOAD: begin
        s0 = 1'b0;
        if (xsel) begin s1 = 1'bx; s2 = 1'bx; end
        else begin s1 = 1'($urandom); s2 = 1'($urandom); end
      end
      K_OPB: begin s0 = 1'b1; s1 = 1'b0; s2 = 1'($urandom); end
      K_OPC: begin s0 = 1'b1; s1 = 1'b1; s2 = 1'b0; end
      default: begin s0 = 1'b1; s1 = 1'b1; s2 = 1'b1; end
    endcase
    case (kind)
      K_LOAD: begin m_acc = aa; m_ov = 1'b0; m_ph = 1; end
      K_OPB: if (m_ph == 1) begin model_apply(mm, bb); m_ph = 2; end else m_err = 1'b1;
      K_OPC: if (m_ph == 2) begin model_apply(mm, cc); m_ph = 3; end else m_err = 1'b1;
      default: if (dn) begin
        if (m_ph == 3) begin
          m_cnt = m_cnt + 8'd1;
          sb.push_back('{res: m_acc, ov: m_ov, cnt: m_cnt});
          m_ph = 0;
        end else m_err = 1'b1;
      end
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = 1'b0; m = 1'($urandom); done = 1'($urandom);
      s0 = 1'($urandom); s1 = 1'($urandom); s2 = 1'($urandom);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    end
  endtask

  task automatic run_seq(input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] cc,
                         input logic mb, input logic mc);
    do_step(K_LOAD, 1'b0, 1'b0, aa, 8'h00, 8'h00, 1'b0);
    do_step(K_OPB, mb, 1'b0, 8'h00, bb, 8'h00, 1'b0);
    do_step(K_OPC, mc, 1'b0, 8'h00, 8'h00, cc, 1'b0);
    do_step(K_FIN, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    idle(2);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_seq_err"}, 32'(seq_err), 32'(m_err));
    check_eq({tag, "_count"}, 32'(result_count), 32'(m_cnt));
  endtask

  // scoreboard consumer: every result_valid pulse must match a queued expectation
  always @(negedge clk) begin
    if (reset_n && result_valid) begin
      pulses++;
      check_eq("valid_one_cycle", 32'(prev_valid), 32'd0);
      if (sb.size() == 0) begin
        check_eq("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check_eq("result", 32'(result), 32'(x.res));
        check_eq("ovf", 32'(ovf), 32'(x.ov));
        check_eq("result_count", 32'(result_count), 32'(x.cnt));
      end
    end
    prev_valid = reset_n && result_valid;
  end

  initial begin
    logic [7:0] held;
    int exp_pulses;
    repeat (3) @(negedge clk);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_valid", 32'(result_valid), 32'd0);
    check_eq("rst_count", 32'(result_count), 32'd0);
    check_eq("rst_seq_err", 32'(seq_err), 32'd0);
    reset_n = 1'b1;
    idle(1);

    // mode 1: 10+20-5 = 25
    run_seq(8'd10, 8'd20, 8'd5, 1'b1, 1'b0);
    check_eq("m1_value", 32'(result), 32'd25);
    check_status("m1");
    // mode 0: 10-3+7 = 14
    run_seq(8'd10, 8'd3, 8'd7, 1'b0, 1'b1);
    check_eq("m0_value", 32'(result), 32'd14);
    check_status("m0");
    // overflow: 100+100 wraps to 0xC8, -100 gives 0x64 with ovf set
    run_seq(8'd100, 8'd100, 8'd100, 1'b1, 1'b0);
    check_eq("ovf_value", 32'(result), 32'd100);
    check_eq("ovf_flag", 32'(ovf), 32'd1);
    run_seq(8'd1, 8'd1, 8'd1, 1'b1, 1'b0);
    check_eq("ovf_cleared", 32'(ovf), 32'd0);
    check_status("ovf");
    // negative-side boundary: -128 - 1 overflows
    run_seq(8'h80, 8'd1, 8'd0, 1'b0, 1'b1);
    check_eq("neg_ovf_flag", 32'(ovf), 32'd1);

    // repeated LOAD is legal; X on s1/s2 during LOAD; e=0 hold mid-sequence
    held = result;
    do_step(K_LOAD, 1'b0, 1'b0, 8'd9, 8'h00, 8'h00, 1'b1);
    do_step(K_LOAD, 1'b0, 1'b0, 8'd50, 8'h00, 8'h00, 1'b1);
    idle(3);
    check_eq("hold_result", 32'(result), 32'(held));
    check_eq("hold_no_x", 32'($isunknown({result, ovf, result_valid, result_count, seq_err})), 32'd0);
    check_status("hold");
    do_step(K_OPB, 1'b1, 1'b0, 8'h00, 8'd20, 8'h00, 1'b0);
    idle(3);
    do_step(K_OPC, 1'b0, 1'b0, 8'h00, 8'h00, 8'd30, 1'b0);
    do_step(K_FIN, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0); // FIN without done: no effect
    do_step(K_FIN, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    idle(2);
    check_eq("hold_value", 32'(result), 32'd40);
    check_status("hold_done");

    // order violation: OPC right after LOAD, then FIN+done from LOADED
    do_step(K_LOAD, 1'b0, 1'b0, 8'd7, 8'h00, 8'h00, 1'b0);
    do_step(K_OPC, 1'b1, 1'b0, 8'h00, 8'h00, 8'd3, 1'b0);
    idle(1);
    check_eq("order_seq_err", 32'(seq_err), 32'd1);
    do_step(K_FIN, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    idle(2);
    check_status("order");
    check_eq("order_result_held", 32'(result), 32'd40);
    // acc must still be 7: 7+2-3 = 6
    do_step(K_OPB, 1'b1, 1'b0, 8'h00, 8'd2, 8'h00, 1'b0);
    do_step(K_OPC, 1'b0, 1'b0, 8'h00, 8'h00, 8'd3, 1'b0);
    do_step(K_FIN, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    idle(2);
    check_eq("order_acc_kept", 32'(result), 32'd6);
    check_status("order_after");

    // reset mid-operation clears everything asynchronously
    do_step(K_LOAD, 1'b0, 1'b0, 8'd55, 8'h00, 8'h00, 1'b0);
    do_step(K_OPB, 1'b1, 1'b0, 8'h00, 8'd4, 8'h00, 1'b0);
    @(posedge clk);
    #2;
    e = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("arst_result", 32'(result), 32'd0);
    check_eq("arst_ovf", 32'(ovf), 32'd0);
    check_eq("arst_count", 32'(result_count), 32'd0);
    check_eq("arst_seq_err", 32'(seq_err), 32'd0);
    check_eq("arst_valid", 32'(result_valid), 32'd0);
    exp_pulses = int'(m_cnt);
    m_acc = '0; m_ov = 1'b0; m_ph = 0; m_err = 1'b0; m_cnt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    // OPB right after reset is out of order from IDLE? Only LOAD is exercised here.
    run_seq(8'd1, 8'd2, 8'd3, 1'b1, 1'b0);
    check_eq("post_rst_value", 32'(result), 32'd0);
    check_status("post_rst");
    exp_pulses = exp_pulses + int'(m_cnt);

    idle(2);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("pulse_total", 32'(pulses), 32'(exp_pulses));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
